// File: rtl/fifo_monitor_if.sv
// Status and strobe bundle between the transaction-layer FIFOs, the
// flow-control controller and the FIFO occupancy monitor.
interface fifo_monitor_if #(
  parameter int CNT_W = 3
);
  logic [4:0]         push;
  logic [4:0]         pop;
  logic               clear_errors;
  logic [1:0]         Umbrales_MFs_internos;
  logic [1:0]         Umbrales_VCs_internos;
  logic [1:0]         Umbrales_Ds_internos;
  logic [4:0]         FIFO_empties;
  logic [4:0]         FIFO_errors;
  logic [4:0]         overflow_flags;
  logic [4:0]         almost_empty;
  logic [4:0]         almost_full;
  logic [5*CNT_W-1:0] occupancy;

  modport master (
    output push, pop, clear_errors,
           Umbrales_MFs_internos, Umbrales_VCs_internos, Umbrales_Ds_internos,
    input  FIFO_empties, FIFO_errors, overflow_flags,
           almost_empty, almost_full, occupancy
  );

  modport slave (
    input  push, pop, clear_errors,
           Umbrales_MFs_internos, Umbrales_VCs_internos, Umbrales_Ds_internos,
    output FIFO_empties, FIFO_errors, overflow_flags,
           almost_empty, almost_full, occupancy
  );
endinterface

// File: rtl/fifo_monitor.sv
// Occupancy tracker for the five transaction-layer FIFOs (MF, VC0, VC1, D0, D1).
// Counts follow push/pop strobes, over/underflow is latched as sticky status,
// and registered controller thresholds become almost-empty/almost-full flags.
module fifo_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic          clk,
  input logic          reset,
  fifo_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [4:0]       err_q;
  logic [4:0]       ovf_q;
  logic [4:0]       set_ovf;
  logic [4:0]       set_unf;
  logic [1:0]       thr_mf_q;
  logic [1:0]       thr_vc_q;
  logic [1:0]       thr_d_q;
  logic [1:0]       thr [5];

  // Next count and error events per FIFO from its push/pop pair.
  always_comb begin
    set_ovf = '0;
    set_unf = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case ({mon.push[i], mon.pop[i]})
        2'b10: begin
          if (cnt_q[i] == DEPTH_C) set_ovf[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
        2'b01: begin
          if (cnt_q[i] == '0) set_unf[i] = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        2'b11: begin
          // An empty FIFO cannot serve the pop, but the push still lands.
          if (cnt_q[i] == '0) begin
            set_unf[i] = 1'b1;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Counts, sticky flags and threshold copies; a new event beats clear_errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      err_q    <= '0;
      ovf_q    <= '0;
      thr_mf_q <= '0;
      thr_vc_q <= '0;
      thr_d_q  <= '0;
    end else begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      if (mon.clear_errors) begin
        err_q <= set_ovf | set_unf;
        ovf_q <= set_ovf;
      end else begin
        err_q <= err_q | set_ovf | set_unf;
        ovf_q <= ovf_q | set_ovf;
      end
      thr_mf_q <= mon.Umbrales_MFs_internos;
      thr_vc_q <= mon.Umbrales_VCs_internos;
      thr_d_q  <= mon.Umbrales_Ds_internos;
    end
  end

  // Status outputs straight from registered counts and thresholds.
  always_comb begin
    thr[0] = thr_mf_q;
    thr[1] = thr_vc_q;
    thr[2] = thr_vc_q;
    thr[3] = thr_d_q;
    thr[4] = thr_d_q;
    mon.FIFO_empties   = '0;
    mon.almost_empty   = '0;
    mon.almost_full    = '0;
    mon.occupancy      = '0;
    mon.FIFO_errors    = err_q;
    mon.overflow_flags = ovf_q;
    for (int i = 0; i < 5; i++) begin
      mon.FIFO_empties[i]            = (cnt_q[i] == '0);
      mon.almost_empty[i]            = (cnt_q[i] <= CNT_W'(thr[i]));
      mon.almost_full[i]             = (cnt_q[i] >= (DEPTH_C - CNT_W'(thr[i])));
      mon.occupancy[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_fifo_monitor.sv
// Directed plus randomized bench for fifo_monitor against an integer model.
module tb_fifo_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk;
  logic reset;

  fifo_monitor_if #(.CNT_W(CNT_W)) bus ();

  fifo_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         passes = 0;
  int         total  = 0;
  int         fails  = 0;
  int         m_cnt [5];
  logic [4:0] m_err;
  logic [4:0] m_ovf;
  int         m_thr_mf, m_thr_vc, m_thr_d;
  logic [1:0] th_mf, th_vc, th_d;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int thr_of(input int i);
    if (i == 0) return m_thr_mf;
    if (i < 3)  return m_thr_vc;
    return m_thr_d;
  endfunction

  task automatic check_all();
    logic [4:0]  e_emp, e_ae, e_af;
    logic [14:0] e_occ;
    for (int i = 0; i < 5; i++) begin
      e_emp[i] = (m_cnt[i] == 0);
      e_ae[i]  = (m_cnt[i] <= thr_of(i));
      e_af[i]  = (m_cnt[i] >= DEPTH - thr_of(i));
      e_occ[i*3 +: 3] = 3'(m_cnt[i]);
    end
    chk("empties",   {10'b0, bus.FIFO_empties},   {10'b0, e_emp});
    chk("errors",    {10'b0, bus.FIFO_errors},    {10'b0, m_err});
    chk("overflow",  {10'b0, bus.overflow_flags}, {10'b0, m_ovf});
    chk("alm_empty", {10'b0, bus.almost_empty},   {10'b0, e_ae});
    chk("alm_full",  {10'b0, bus.almost_full},    {10'b0, e_af});
    chk("occupancy", bus.occupancy,               e_occ);
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic [4:0] p, input logic [4:0] q, input logic clr, input logic rst);
    bus.push = p;
    bus.pop = q;
    bus.clear_errors = clr;
    bus.Umbrales_MFs_internos = th_mf;
    bus.Umbrales_VCs_internos = th_vc;
    bus.Umbrales_Ds_internos = th_d;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_err = '0;
      m_ovf = '0;
      m_thr_mf = 0;
      m_thr_vc = 0;
      m_thr_d = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        int c = m_cnt[i];
        bit ov = 0;
        bit un = 0;
        if (p[i] && !q[i]) begin
          if (c == DEPTH) ov = 1; else c = c + 1;
        end else if (!p[i] && q[i]) begin
          if (c == 0) un = 1; else c = c - 1;
        end else if (p[i] && q[i] && c == 0) begin
          un = 1;
          c = 1;
        end
        m_cnt[i] = c;
        if (clr) begin
          m_err[i] = ov | un;
          m_ovf[i] = ov;
        end else begin
          m_err[i] = m_err[i] | ov | un;
          m_ovf[i] = m_ovf[i] | ov;
        end
      end
      m_thr_mf = int'(th_mf);
      m_thr_vc = int'(th_vc);
      m_thr_d = int'(th_d);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [4:0] p, q;
    int load [5];
    th_mf = 0; th_vc = 0; th_d = 0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_err = '0; m_ovf = '0;
    m_thr_mf = 0; m_thr_vc = 0; m_thr_d = 0;

    // Reset then idle.
    step(5'h00, 5'h00, 1'b0, 1'b1);
    repeat (3) step(5'h00, 5'h00, 1'b0, 1'b0);
    chk("tp_idle_empties", {10'b0, bus.FIFO_empties}, 15'h001f);
    chk("tp_idle_ae",      {10'b0, bus.almost_empty}, 15'h001f);
    chk("tp_idle_af",      {10'b0, bus.almost_full},  15'h0000);

    // MF fill with threshold 1.
    th_mf = 2'd1;
    step(5'h01, 5'h00, 1'b0, 1'b0);
    chk("tp_mf_ae1", {14'b0, bus.almost_empty[0]}, 15'h0001);
    step(5'h01, 5'h00, 1'b0, 1'b0);
    step(5'h01, 5'h00, 1'b0, 1'b0);
    chk("tp_mf_occ3", {12'b0, bus.occupancy[2:0]}, 15'h0003);
    chk("tp_mf_af3",  {14'b0, bus.almost_full[0]}, 15'h0001);

    // VC0 overflow, then full push+pop.
    repeat (4) step(5'h02, 5'h00, 1'b0, 1'b0);
    step(5'h02, 5'h00, 1'b0, 1'b0);
    chk("tp_vc0_err", {10'b0, bus.FIFO_errors},    15'h0002);
    chk("tp_vc0_ovf", {10'b0, bus.overflow_flags}, 15'h0002);
    step(5'h02, 5'h02, 1'b0, 1'b0);
    chk("tp_vc0_occ", {12'b0, bus.occupancy[5:3]}, 15'h0004);

    // D1 underflow, then push+pop at empty.
    step(5'h00, 5'h10, 1'b0, 1'b0);
    chk("tp_d1_err", {14'b0, bus.FIFO_errors[4]},    15'h0001);
    chk("tp_d1_ovf", {14'b0, bus.overflow_flags[4]}, 15'h0000);
    step(5'h10, 5'h10, 1'b0, 1'b0);
    chk("tp_d1_occ", {12'b0, bus.occupancy[14:12]}, 15'h0001);

    // D0 error, clear alone, then clear coinciding with underflow.
    step(5'h00, 5'h08, 1'b0, 1'b0);
    step(5'h00, 5'h00, 1'b1, 1'b0);
    chk("tp_d0_clr", {14'b0, bus.FIFO_errors[3]}, 15'h0000);
    step(5'h00, 5'h08, 1'b1, 1'b0);
    chk("tp_d0_set_wins", {14'b0, bus.FIFO_errors[3]}, 15'h0001);

    // Load counts 2,3,1,4,0 and reset with all pushes active.
    step(5'h00, 5'h00, 1'b0, 1'b1);
    load = '{2, 3, 1, 4, 0};
    for (int k = 0; k < 4; k++) begin
      p = '0;
      for (int i = 0; i < 5; i++) p[i] = (load[i] > k);
      step(p, 5'h00, 1'b0, 1'b0);
    end
    chk("tp_load_occ", bus.occupancy, 15'b000_100_001_011_010);
    step(5'h1f, 5'h00, 1'b0, 1'b1);
    chk("tp_rst_occ",     bus.occupancy,             15'h0000);
    chk("tp_rst_empties", {10'b0, bus.FIFO_empties}, 15'h001f);
    chk("tp_rst_err",     {10'b0, bus.FIFO_errors},  15'h0000);

    // Randomized traffic: push-biased then pop-biased phases.
    for (int n = 0; n < 400; n++) begin
      th_mf = 2'($urandom); th_vc = 2'($urandom); th_d = 2'($urandom);
      if (n < 200) begin
        p = 5'($urandom);
        q = 5'($urandom) & 5'($urandom);
      end else begin
        p = 5'($urandom) & 5'($urandom);
        q = 5'($urandom);
      end
      step(p, q, ($urandom_range(7) == 0), ($urandom_range(59) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
